// File: rtl/command_sequencer_if.sv
// Command/status bundle between the command PIO and command_sequencer.
// master = PIO side (drives cmd), slave = sequencer side.
interface command_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       cmd;
    logic [2:0]       status;
    logic             run;
    logic             run_start;
    logic             run_done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output cmd,
        input  status,
        input  run,
        input  run_start,
        input  run_done,
        input  cycle_count
    );

    modport slave (
        input  cmd,
        output status,
        output run,
        output run_start,
        output run_done,
        output cycle_count
    );
endinterface

// File: rtl/command_sequencer.sv
// Toggle-strobed command sequencer: START/ABORT/CLEAR a fixed-length timed run.
// Define COMMAND_SEQUENCER_SYNC_EN to use a two-flop synchronizer as the capture stage.
module command_sequencer #(
    parameter int unsigned RUN_CYCLES   = 1000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input logic                clk,
    input logic                reset_n,
    command_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_ABORT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] RUN_PENULT  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [7:0]       FLUSH_PENULT = 8'(FLUSH_CYCLES - 1);

    logic [2:0]       cmd_r;
    logic             tog_prev;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       flush_q, flush_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             aborted_q, aborted_d;
    logic             run_start_q, run_start_d;
    logic             run_done_q, run_done_d;
    logic             run_q;
    logic             busy_q;

    logic       cmd_new;
    logic [1:0] op;
    logic       is_start, is_abort, is_clear;

`ifdef COMMAND_SEQUENCER_SYNC_EN
    logic [2:0] cmd_meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_meta <= 3'b000;
            cmd_r    <= 3'b000;
        end else begin
            cmd_meta <= bus.cmd;
            cmd_r    <= cmd_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_r <= 3'b000;
        end else begin
            cmd_r <= bus.cmd;
        end
    end
`endif

    // A command exists only on the cycle the captured toggle differs from the last one seen.
    assign cmd_new  = (cmd_r[2] != tog_prev);
    assign op       = cmd_r[1:0];
    assign is_start = cmd_new && (op == OP_START);
    assign is_abort = cmd_new && (op == OP_ABORT);
    assign is_clear = cmd_new && (op == OP_CLEAR);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        done_d      = done_q;
        error_d     = error_q;
        aborted_d   = aborted_q;
        run_start_d = 1'b0;
        run_done_d  = 1'b0;

        if (is_clear) begin
            done_d  = 1'b0;
            error_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    aborted_d   = 1'b0;
                    run_start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (is_start) begin
                    error_d = 1'b1;
                end
                // Abort takes priority over normal completion on the final run cycle.
                if (is_abort) begin
                    state_d   = ST_FLUSH;
                    flush_d   = 8'd0;
                    error_d   = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    if (cnt_q != RUN_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= RUN_PENULT) begin
                        state_d = ST_FLUSH;
                        flush_d = 8'd0;
                    end
                end
            end
            ST_FLUSH: begin
                if (is_start) begin
                    error_d = 1'b1;
                end
                flush_d = flush_q + 8'd1;
                if (flush_q == FLUSH_PENULT) begin
                    state_d = ST_IDLE;
                    // Setting done here overrides a CLEAR landing on the same cycle.
                    if (!aborted_q) begin
                        done_d     = 1'b1;
                        run_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_prev    <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            flush_q     <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            aborted_q   <= 1'b0;
            run_start_q <= 1'b0;
            run_done_q  <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tog_prev    <= cmd_r[2];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            error_q     <= error_d;
            aborted_q   <= aborted_d;
            run_start_q <= run_start_d;
            run_done_q  <= run_done_d;
            run_q       <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign bus.status      = {error_q, done_q, busy_q};
    assign bus.run         = run_q;
    assign bus.run_start   = run_start_q;
    assign bus.run_done    = run_done_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Self-checking bench for command_sequencer: directed vector table plus random commands
// checked every cycle against a behavioural model.
module tb_command_sequencer;

    localparam int RUN = 8;
    localparam int FL  = 4;
    localparam int CW  = 16;
`ifdef COMMAND_SEQUENCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int D = LAT + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    command_sequencer_if #(.CNT_W(CW)) bus ();

    command_sequencer #(
        .RUN_CYCLES  (RUN),
        .CNT_W       (CW),
        .FLUSH_CYCLES(FL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // {status, run, run_start, run_done, cycle_count}
    function automatic logic [21:0] outs();
        return {bus.status, bus.run, bus.run_start, bus.run_done, bus.cycle_count};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%b run=%b rs=%b rd=%b cnt=%0d, want st=%b run=%b rs=%b rd=%b cnt=%0d",
                     name, act[21:19], act[18], act[17], act[16], act[15:0],
                     exp[21:19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Behavioural model: remaining-cycle counters and flags, commands delayed by LAT edges.
    bit         m_busy, m_running, m_done, m_err, m_ab, m_sp, m_dp, m_tog;
    int         m_cnt, m_flush_left;
    logic [2:0] hist[$];

    task automatic mreset();
        m_busy = 0; m_running = 0; m_done = 0; m_err = 0; m_ab = 0;
        m_sp = 0; m_dp = 0; m_tog = 0; m_cnt = 0; m_flush_left = 0;
        hist.delete();
    endtask

    task automatic mstep();
        logic [2:0] c;
        bit         nw;
        c = (hist.size() >= LAT) ? hist[hist.size() - LAT] : 3'b000;
        hist.push_back(bus.cmd);
        if (hist.size() > 4) void'(hist.pop_front());
        nw    = (c[2] != m_tog);
        m_tog = c[2];
        m_sp  = 0;
        m_dp  = 0;
        if (nw && c[1:0] == 2'b11) begin
            m_done = 0;
            m_err  = 0;
        end
        if (!m_busy) begin
            if (nw && c[1:0] == 2'b01) begin
                m_busy = 1; m_running = 1; m_cnt = 0;
                m_done = 0; m_err = 0; m_ab = 0; m_sp = 1;
            end
        end else if (m_running) begin
            if (nw && c[1:0] == 2'b01) m_err = 1;
            if (nw && c[1:0] == 2'b10) begin
                m_running = 0; m_flush_left = FL; m_err = 1; m_ab = 1;
            end else begin
                m_cnt++;
                if (m_cnt == RUN) begin
                    m_running    = 0;
                    m_flush_left = FL;
                end
            end
        end else begin
            if (nw && c[1:0] == 2'b01) m_err = 1;
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_busy = 0;
                if (!m_ab) begin
                    m_done = 1;
                    m_dp   = 1;
                end
            end
        end
    endtask

    function automatic logic [21:0] model_exp();
        return {m_err, m_done, m_busy, m_running, m_sp, m_dp, 16'(m_cnt)};
    endfunction

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) mreset();
            else mstep();
        end
    end

    bit chk_en = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) check("model", outs(), model_exp());
        end
    end

    typedef struct {
        logic [2:0]  cmd;
        int          adv;
        logic [2:0]  st;
        logic        run;
        logic        rs;
        logic        rd;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [2:0] cmd, input int adv, input logic [2:0] st,
                                input logic run, input logic rs, input logic rd, input int cnt);
        vec_t v;
        v.cmd = cmd; v.adv = adv; v.st = st; v.run = run; v.rs = rs; v.rd = rd; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        // Normal run
        add(3'b101, D,      3'b001, 1, 1, 0, 0);
        add(3'b101, 1,      3'b001, 1, 0, 0, 1);
        add(3'b101, 6,      3'b001, 1, 0, 0, 7);
        add(3'b101, 1,      3'b001, 0, 0, 0, 8);
        add(3'b101, 3,      3'b001, 0, 0, 0, 8);
        add(3'b101, 1,      3'b010, 0, 0, 1, 8);
        add(3'b101, 1,      3'b010, 0, 0, 0, 8);
        add(3'b011, D,      3'b000, 0, 0, 0, 8);
        // Abort after 3 run cycles
        add(3'b101, D,      3'b001, 1, 1, 0, 0);
        add(3'b101, 3,      3'b001, 1, 0, 0, 3);
        add(3'b010, D,      3'b101, 0, 0, 0, 2 + D);
        add(3'b010, 3,      3'b101, 0, 0, 0, 2 + D);
        add(3'b010, 1,      3'b100, 0, 0, 0, 2 + D);
        // Rejected START, then CLEAR
        add(3'b101, D,      3'b001, 1, 1, 0, 0);
        add(3'b001, D,      3'b101, 1, 0, 0, D);
        add(3'b001, 12 - D, 3'b110, 0, 0, 1, 8);
        add(3'b111, D,      3'b000, 0, 0, 0, 8);
        // ABORT on the final run cycle
        add(3'b001, D,      3'b001, 1, 1, 0, 0);
        add(3'b001, 8 - D,  3'b001, 1, 0, 0, 8 - D);
        add(3'b110, D,      3'b101, 0, 0, 0, 7);
        add(3'b110, 4,      3'b100, 0, 0, 0, 7);
        // CLEAR on the flush exit cycle
        add(3'b001, D,      3'b001, 1, 1, 0, 0);
        add(3'b001, 12 - D, 3'b001, 0, 0, 0, 8);
        add(3'b111, D,      3'b010, 0, 0, 1, 8);
        add(3'b111, 1,      3'b010, 0, 0, 0, 8);
        // NOP and ABORT while idle have no effect
        add(3'b000, D,      3'b010, 0, 0, 0, 8);
        add(3'b110, D,      3'b010, 0, 0, 0, 8);

        bus.cmd = 3'b000;
        reset_n = 1'b0;
        chk_en  = 1;
        repeat (3) @(negedge clk);
        check("in_reset", outs(), 22'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", outs(), 22'd0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            bus.cmd = tbl[i].cmd;
            repeat (tbl[i].adv) @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].st, tbl[i].run, tbl[i].rs, tbl[i].rd, 16'(tbl[i].cnt)});
        end

        // Random commands, each toggle value held long enough for the capture stage.
        repeat (300) begin
            bus.cmd = 3'($urandom);
            repeat ($urandom_range(LAT, LAT + 6)) @(negedge clk);
        end

        // Reset in the middle of a run
        repeat (20) @(negedge clk);
        bus.cmd = {~bus.cmd[2], 2'b01};
        repeat (LAT + 3) @(negedge clk);
        check("pre_reset_run", {21'd0, bus.run}, 22'd1);
        #2 reset_n = 1'b0;
        bus.cmd = 3'b000;
        #1 check("async_reset", outs(), 22'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/command_sequencer.md
# command_sequencer

Executes 3-bit software commands issued through the command PIO. It sits directly downstream of the PIO's `out_port` and drives the same PIO's `in_port` with status. A toggle bit marks each new command. Accepted commands start, abort or acknowledge a fixed-length timed run that gates the downstream datapath.

## Interface
Parameters:
- `RUN_CYCLES`, default 1000: length of a run in clk cycles. Legal range is 1..2^CNT_W-1.
- `CNT_W`, default 16: width of the cycle counter.
- `FLUSH_CYCLES`, default 4: idle-gap cycles after every run or abort. Legal range is 1..255.

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `cmd`  in  3: from PIO `out_port`. cmd[2] is the toggle strobe; cmd[1:0] is the opcode.
- `status`  out  3: to PIO `in_port`, laid out as {error, done, busy}.
- `run`  out  1: datapath enable.
- `run_start`  out  1: single-cycle pulse when a START is accepted.
- `run_done`  out  1: single-cycle pulse when a run completes normally.
- `cycle_count`  out  CNT_W: number of cycles `run` has been high in the current or last run.

## Operation
- Opcodes:
  - 00 NOP
  - 01 START
  - 10 ABORT
  - 11 CLEAR
- **Capture:** cmd passes through the capture stage into cmd_r.
- **Command detection:** a command is recognised when cmd_r[2] != tog_prev. tog_prev then takes the value of cmd_r[2] on that same edge, so each toggle yields exactly one command.
- **States:** IDLE, RUN and FLUSH. busy = (state != IDLE).
- **IDLE:**
  - START: go to RUN, set cycle_count = 0, clear done, error and the aborted flag, pulse run_start.
  - ABORT and NOP: no effect.
  - CLEAR: clear done and error.
- **RUN:**
  - `run` = 1 and cycle_count increments by 1 every cycle.
  - When cycle_count becomes RUN_CYCLES, go to FLUSH. `run` is high for exactly RUN_CYCLES cycles.
- **FLUSH:**
  - `run` = 0 and busy = 1.
  - An internal flush counter runs for FLUSH_CYCLES cycles, then the block returns to IDLE.
  - On exit without the aborted flag: set done and pulse run_done.
  - On exit with the aborted flag: done stays 0.
- **ABORT in RUN:** go to FLUSH immediately, set error and the aborted flag. cycle_count holds its value.
- **ABORT in FLUSH:** no effect.
- **START in RUN or FLUSH:** rejected. error is set and the state is unchanged.
- **CLEAR in RUN or FLUSH:** clears done and error. It has no effect on the state.
- **Simultaneous events:**
  - ABORT accepted on the final RUN cycle: ABORT wins. error is set and no done follows.
  - CLEAR accepted on the FLUSH exit cycle: the set of done wins.
- **Counter width:** cycle_count saturates at RUN_CYCLES and never wraps. The flush counter is 8 bits.

## Timing
- **Reset values:**
  - status = 3'b000, run = 0, run_start = 0, run_done = 0, cycle_count = 0.
  - state = IDLE, cmd_r = 0, tog_prev = 0.
  - The PIO also resets `out_port` to 0, so no spurious command is seen after reset.
- **All outputs are registered.**
- **Command latency without the macro:** cmd changes before edge k. cmd_r updates at edge k. The state, status and pulses update at edge k+1.
- **START timing:** `run` rises after edge k+1 and stays high for RUN_CYCLES cycles. busy falls FLUSH_CYCLES cycles after `run` falls.
- **run_done timing:** run_done asserts in the same cycle that done rises and busy falls.
- **Toggle rate:** one command may be accepted per cycle. Software must hold each toggle value at least 1 cycle (2 cycles with the macro).
- **Reset mid-run:** asserting reset_n low drops `run` and all status bits asynchronously. No run_done is produced.

## Configuration
- **`COMMAND_SEQUENCER_SYNC_EN` defined:** the capture stage is a two-flop synchronizer. Use this when the command source is in another clock domain. Command latency grows by 1 cycle: effect lands at edge k+2.
- **Macro undefined:** the capture stage is a single register, as described above.
- **Unaffected either way:** all other behaviour and the reset values.

## Test plan
- **Reset and idle:** hold reset_n low, then release it with cmd = 3'b000. Require status = 000, run = 0 and cycle_count = 0 for 20 cycles.
- **Normal run:** RUN_CYCLES = 8, FLUSH_CYCLES = 4. Set cmd = 3'b101.
  - Require run_start after 2 edges, then `run` high for exactly 8 cycles with cycle_count reaching 8.
  - Require busy for 4 more cycles, then status = 010 with a single run_done pulse.
- **Abort:** START, then after 3 run cycles set cmd = 3'b010 (toggle back with ABORT).
  - Require `run` to drop 2 edges later with cycle_count holding at 4 or 5 (latency-exact), then status = 100 after the flush. No run_done.
- **Rejected START and CLEAR:** START, then while busy toggle START again.
  - Require status = 101 and `run` unaffected.
  - After completion, status = 110. Toggle CLEAR and require status = 000.
- **Collisions:**
  - ABORT timed to land on the final run cycle: require error = 1, done = 0.
  - CLEAR landing on the FLUSH exit cycle: require done = 1.
- **Macro build:** repeat the normal run with `COMMAND_SEQUENCER_SYNC_EN` defined. Require run_start after 3 edges and otherwise identical results.
